// File: rtl/fetch_stage_pkg.sv
// Shared instruction-format constants for the 16-bit MIPS pipeline.
// Imported by fetch, decode and the instruction memory.
package fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int RS_MSB     = 12;
    localparam int RS_LSB     = 10;
    localparam int RT_MSB     = 9;
    localparam int RT_LSB     = 7;
    localparam int RD_MSB     = 6;
    localparam int RD_LSB     = 4;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_ADDI  = 3'd1,
        OP_LW    = 3'd2,
        OP_SW    = 3'd3,
        OP_BEQ   = 3'd4,
        OP_BNE   = 3'd5,
        OP_J     = 3'd6,
        OP_JAL   = 3'd7
    } opcode_e;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] ins);
        return ins[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// Word-addressed instruction memory: combinational read, synchronous
// program-load write. Contents survive reset.
module instr_mem
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge word, so a same-cycle write is not forwarded.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory and the
// IF/ID pipeline register with stall, redirect and a fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter logic [PC_W-1:0]    RESET_PC = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc_plus1,
    output logic               if_valid,
    output logic [PC_W-1:0]    pc,
    output logic [15:0]        fetch_count
);

    logic [INSTR_W-1:0] rd_data;
    logic [PC_W-1:0]    pc_next;

    instr_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign pc_next = pc + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= NOP;
            pc_plus1    <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_en) begin
            pc          <= redirect_pc;
            instruction <= NOP;
            pc_plus1    <= '0;
            if_valid    <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_next;
            instruction <= rd_data;
            pc_plus1    <= pc_next;
            if_valid    <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: table of per-edge stimulus
// and expected IF/ID state, plus a counter saturation run.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [15:0] instruction;
    logic [15:0] pc_plus1;
    logic        if_valid;
    logic [15:0] pc;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W(8),
        .RESET_PC(16'h0000),
        .NOP(16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .pc_plus1    (pc_plus1),
        .if_valid    (if_valid),
        .pc          (pc),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        we;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] e_instr;
        logic [15:0] e_pp1;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic r, input logic s, input logic rd,
        input logic [15:0] rp, input logic w,
        input logic [7:0] wa, input logic [15:0] wd,
        input logic [15:0] ei, input logic [15:0] ep,
        input logic ev, input logic [15:0] epc,
        input logic [15:0] ec
    );
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp;
        v.we = w; v.waddr = wa; v.wdata = wd;
        v.e_instr = ei; v.e_pp1 = ep; v.e_valid = ev;
        v.e_pc = epc; v.e_cnt = ec;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall;
        redirect_en = v.redir; redirect_pc = v.rpc;
        prog_we = v.we; prog_addr = v.waddr; prog_data = v.wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.instruction", i), instruction, v.e_instr);
        chk($sformatf("v%0d.pc_plus1", i), pc_plus1, v.e_pp1);
        chk($sformatf("v%0d.if_valid", i), {15'd0, if_valid},
            {15'd0, v.e_valid});
        chk($sformatf("v%0d.pc", i), pc, v.e_pc);
        chk($sformatf("v%0d.fetch_count", i), fetch_count, v.e_cnt);
    endtask

    initial begin
        // r  s  rd rpc      we wa     wd        instr     pp1     v  pc       cnt
        add(1, 0, 0, 16'h0,  1, 8'd0,  16'h2580, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd1,  16'h1234, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd2,  16'hABCD, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd3,  16'h0F0F, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd4,  16'h0000, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd5,  16'h0000, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(1, 0, 0, 16'h0,  1, 8'd255,16'hBEEF, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h2580, 16'h1, 1, 16'h1,  16'd1);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd2);
        add(0, 1, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd2);
        add(0, 1, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd2);
        add(0, 1, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd2);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'hABCD, 16'h3, 1, 16'h3,  16'd3);
        add(0, 0, 1, 16'h1,  0, 8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'h1,  16'd3);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd4);
        add(0, 1, 1, 16'h4,  0, 8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'h4,  16'd4);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h0000, 16'h5, 1, 16'h5,  16'd5);
        add(0, 0, 0, 16'h0,  1, 8'd5,  16'h7777, 16'h0000, 16'h6, 1, 16'h6,  16'd6);
        add(0, 0, 1, 16'h5,  0, 8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'h5,  16'd6);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h7777, 16'h6, 1, 16'h6,  16'd7);
        add(0, 0, 1, 16'h3,  0, 8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'h3,  16'd7);
        add(0, 0, 1, 16'hFFFF,0,8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'hFFFF,16'd7);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'hBEEF, 16'h0, 1, 16'h0,  16'd8);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h2580, 16'h1, 1, 16'h1,  16'd9);
        add(1, 1, 1, 16'h40, 1, 8'd6,  16'h6666, 16'h0000, 16'h0, 0, 16'h0,  16'd0);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h2580, 16'h1, 1, 16'h1,  16'd1);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h1234, 16'h2, 1, 16'h2,  16'd2);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'hABCD, 16'h3, 1, 16'h3,  16'd3);
        add(0, 0, 1, 16'h6,  0, 8'd0,  16'h0000, 16'h0000, 16'h0, 0, 16'h6,  16'd3);
        add(0, 0, 0, 16'h0,  0, 8'd0,  16'h0000, 16'h6666, 16'h7, 1, 16'h7,  16'd4);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Saturation: from reset, 65535 fetches reach FFFF, one more holds it.
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; prog_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            @(posedge clk);
        end
        #1;
        chk("sat.count_at_max", fetch_count, 16'hFFFF);
        chk("sat.pc_before_wrap", pc, 16'hFFFF);
        @(posedge clk); #1;
        chk("sat.count_holds", fetch_count, 16'hFFFF);
        chk("sat.pc_wraps", pc, 16'h0000);
        chk("sat.pc_plus1_wraps", pc_plus1, 16'h0000);
        chk("sat.instr_alias", instruction, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
